// File: rtl/calc_times_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_times_pkg
// Brief    : Shared state encoding, default widths and slice helper for the
//            calc_times scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package calc_times_pkg;

    localparam int c_def_pw      = 32;
    localparam int c_def_tw      = 64;
    localparam int c_def_n_param = 5;
    localparam int c_def_n_time  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Low bit of element idx inside a flattened vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_times_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_times_seq_if
// Brief    : Launch/result handshake between the scheduler and the shared
//            timing engine.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_times_seq_if
    import calc_times_pkg::*;
#(
    parameter int N_PARAM = c_def_n_param,
    parameter int PW      = c_def_pw,
    parameter int N_TIME  = c_def_n_time,
    parameter int TW      = c_def_tw
);
    logic                   eng_start;
    logic [N_PARAM*PW-1:0]  eng_params;
    logic [N_TIME*TW-1:0]   eng_timing;
    logic                   eng_done;

    modport master (output eng_start, output eng_params,
                    input  eng_timing, input  eng_done);
    modport slave  (input  eng_start, input  eng_params,
                    output eng_timing, output eng_done);
endinterface
`default_nettype wire

// File: rtl/calc_times_prienc.sv
`default_nettype none
// ============================================================================
// Module   : calc_times_prienc
// Brief    : Lowest-set-bit priority encoder with an empty flag.
// Revision : 1.0 - initial release
// ============================================================================
module calc_times_prienc #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic [IW-1:0] o_idx,
    output logic          o_none
);
    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx  = IW'(i);
                o_none = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/calc_times_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_times_seq
// Brief    : Time-multiplexes one shared timing engine across N_CH channels.
// Revision : 1.0 - initial release
// ============================================================================
module calc_times_seq
    import calc_times_pkg::*;
#(
    parameter int N_CH    = 5,
    parameter int N_PARAM = c_def_n_param,
    parameter int PW      = c_def_pw,
    parameter int N_TIME  = c_def_n_time,
    parameter int TW      = c_def_tw,
    parameter int GAP     = 20,
    parameter int TIMEOUT = 65535
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic [N_CH-1:0]                        ch_mask,
    input  logic [N_CH*N_PARAM*PW-1:0]             params,
    output logic                                   busy,
    output logic                                   done,
    output logic [N_CH*N_TIME*TW-1:0]              timing,
    output logic [N_CH-1:0]                        ch_valid,
    output logic                                   timeout_err,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] err_ch,
    calc_times_seq_if.master                       eng
);
    localparam int c_slice_p = N_PARAM * PW;
    localparam int c_slice_t = N_TIME * TW;
    localparam int c_cw      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_tow     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int c_gw      = (GAP > 1) ? $clog2(GAP + 1) : 1;

    state_t                     r_state, w_next;
    logic [N_CH-1:0]            r_pending;
    logic [N_CH*c_slice_p-1:0]  r_snap;
    logic [c_cw-1:0]            r_cur, w_sel;
    logic                       w_none;
    logic [c_tow-1:0]           r_to_cnt;
    logic [c_gw-1:0]            r_gap_cnt;
    logic [c_slice_p-1:0]       r_eng_params;
    logic                       r_done;
    logic                       w_accept, w_to_hit, w_gap_end;
    logic                       w_eng_start, w_busy;

    calc_times_prienc #(.N(N_CH), .IW(c_cw)) u_prienc (
        .i_req  (r_pending),
        .o_idx  (w_sel),
        .o_none (w_none)
    );

    assign w_accept  = (r_state == ST_IDLE) && start && !abort;
    assign w_to_hit  = (TIMEOUT != 0) && (r_to_cnt == c_tow'(TIMEOUT - 1));
    // The GAP state also absorbs the result-latch cycle, so it lasts GAP+1.
    assign w_gap_end = (r_gap_cnt == c_gw'(GAP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_eng_start = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SELECT;
            ST_SELECT: begin
                w_busy = 1'b1;
                w_next = w_none ? ST_DONE : ST_LAUNCH;
            end
            ST_LAUNCH: begin
                w_busy      = 1'b1;
                w_eng_start = !abort;
                w_next      = ST_WAIT;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (eng.eng_done || w_to_hit)
                    w_next = (GAP == 0) ? ST_SELECT : ST_GAP;
            end
            ST_GAP: begin
                w_busy = 1'b1;
                if (w_gap_end) w_next = ST_SELECT;
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= '0;
            r_snap        <= '0;
            r_cur         <= '0;
            r_to_cnt      <= '0;
            r_gap_cnt     <= '0;
            r_eng_params  <= '0;
            r_done        <= 1'b0;
            timing        <= '0;
            ch_valid      <= '0;
            timeout_err   <= 1'b0;
            err_ch        <= '0;
        end else begin
            r_done <= (r_state == ST_DONE) && !abort;
            if (abort) begin
                r_pending <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_accept) begin
                        r_snap      <= params;
                        r_pending   <= ch_mask;
                        ch_valid    <= '0;
                        timeout_err <= 1'b0;
                    end
                    ST_SELECT: if (!w_none) begin
                        r_cur        <= w_sel;
                        r_eng_params <= r_snap[slice_lo(int'(w_sel), c_slice_p) +: c_slice_p];
                    end
                    ST_LAUNCH: r_to_cnt <= '0;
                    ST_WAIT: begin
                        if (eng.eng_done) begin
                            timing[slice_lo(int'(r_cur), c_slice_t) +: c_slice_t] <= eng.eng_timing;
                            ch_valid[r_cur]  <= 1'b1;
                            r_pending[r_cur] <= 1'b0;
                            r_gap_cnt        <= '0;
                        end else if (w_to_hit) begin
                            timeout_err      <= 1'b1;
                            err_ch           <= r_cur;
                            r_pending[r_cur] <= 1'b0;
                            r_gap_cnt        <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + c_tow'(1);
                        end
                    end
                    ST_GAP: r_gap_cnt <= r_gap_cnt + c_gw'(1);
                    default: ;
                endcase
            end
        end
    end

    assign busy            = w_busy;
    assign done            = r_done;
    assign eng.eng_start   = w_eng_start;
    assign eng.eng_params  = r_eng_params;
endmodule
`default_nettype wire

// File: tb/tb_calc_times_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_times_seq
// Brief    : Scoreboard bench for calc_times_seq with a fixed-latency engine stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_times_seq;
    localparam int N_CH = 5, N_PARAM = 5, PW = 32, N_TIME = 4, TW = 64;
    localparam int GAP = 20, TIMEOUT = 100, CW = 3;
    localparam int PV = N_CH*N_PARAM*PW, TV = N_CH*N_TIME*TW;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [N_CH-1:0] ch_mask = '0;
    logic [PV-1:0]   params  = '0;
    logic            busy, done, timeout_err;
    logic [TV-1:0]   timing;
    logic [N_CH-1:0] ch_valid;
    logic [CW-1:0]   err_ch;

    calc_times_seq_if #(.N_PARAM(N_PARAM), .PW(PW), .N_TIME(N_TIME), .TW(TW)) eng_if ();

    calc_times_seq #(.N_CH(N_CH), .N_PARAM(N_PARAM), .PW(PW), .N_TIME(N_TIME),
                     .TW(TW), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ch_mask(ch_mask),
        .params(params), .busy(busy), .done(done), .timing(timing),
        .ch_valid(ch_valid), .timeout_err(timeout_err), .err_ch(err_ch), .eng(eng_if));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    int skip_ch = -1;

    typedef struct { logic [N_PARAM*PW-1:0] prm; int cy; } launch_t;
    typedef struct { logic [N_CH-1:0] valid; logic [TV-1:0] tim; logic terr; logic [CW-1:0] ech; int cy; } done_t;
    launch_t lq[$];
    done_t   dq[$];

    logic [TV-1:0]   m_tim   = '0;
    logic [N_CH-1:0] m_valid = '0;
    logic            m_terr  = 1'b0;
    logic [CW-1:0]   m_ech   = '0;

    task automatic chk(input string name, input logic [TV-1:0] act, input logic [TV-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pword(input int tag, input int ch, input int j);
        return {8'(tag), 8'(j), 8'h5A, 8'(ch)};
    endfunction

    function automatic logic [PV-1:0] make_params(input int tag);
        logic [PV-1:0] v;
        for (int c = 0; c < N_CH; c++)
            for (int j = 0; j < N_PARAM; j++)
                v[(c*N_PARAM+j)*PW +: PW] = pword(tag, c, j);
        return v;
    endfunction

    // Expected launches and final state of one run; skip is the unanswered channel.
    task automatic plan_run(input int tag, input logic [N_CH-1:0] mask, input int skip, input int t0);
        logic [PV-1:0] p;
        launch_t l;
        done_t d;
        int L, last_end;
        p = make_params(tag);
        L = t0 + 2;
        last_end = -1;
        m_valid = '0;
        m_terr  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i]) begin
                l.prm = p[i*N_PARAM*PW +: N_PARAM*PW];
                l.cy  = L;
                lq.push_back(l);
                if (i == skip) begin
                    m_terr = 1'b1;
                    m_ech  = CW'(i);
                    last_end = L + TIMEOUT;
                end else begin
                    m_valid[i] = 1'b1;
                    for (int k = 0; k < N_TIME; k++)
                        m_tim[(i*N_TIME+k)*TW +: TW] = {pword(tag, i, 0), 32'(k)};
                    last_end = L + 10;
                end
                L = last_end + GAP + 3;
            end
        end
        d.valid = m_valid; d.tim = m_tim; d.terr = m_terr; d.ech = m_ech;
        d.cy = (last_end < 0) ? t0 + 3 : last_end + GAP + 4;
        dq.push_back(d);
    endtask

    task automatic go(input int tag, input logic [N_CH-1:0] mask, output int t0);
        @(posedge clk); #1;
        params = make_params(tag); ch_mask = mask; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; ch_mask = ~mask; params = make_params(tag + 128);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (lq.size() == 0 && dq.size() == 0) break;
            @(posedge clk); #1;
        end
        if (lq.size() + dq.size() != 0) begin
            chk("drain_budget", lq.size() + dq.size(), 0);
            lq.delete(); dq.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timing"}, timing, 0);
        chk({tag, "_ch_valid"}, ch_valid, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_err_ch"}, err_ch, 0);
        chk({tag, "_eng_start"}, eng_if.eng_start, 0);
        chk({tag, "_eng_params"}, eng_if.eng_params, 0);
    endtask

    // Engine stub: answers 10 cycles after launch unless the channel is skipped.
    initial begin
        logic [PW-1:0] p0;
        eng_if.eng_done   = 1'b0;
        eng_if.eng_timing = '0;
        forever begin
            @(negedge clk);
            if (eng_if.eng_start) begin
                p0 = eng_if.eng_params[PW-1:0];
                if (int'(p0[7:0]) != skip_ch) begin
                    repeat (10) @(posedge clk);
                    #1;
                    for (int k = 0; k < N_TIME; k++)
                        eng_if.eng_timing[k*TW +: TW] = {p0, 32'(k)};
                    eng_if.eng_done = 1'b1;
                    @(posedge clk); #1;
                    eng_if.eng_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT launches or completes.
    always @(negedge clk) begin
        launch_t l;
        done_t d;
        if (!reset) begin
            if (eng_if.eng_start) begin
                if (lq.size() == 0) chk("unexpected_launch", 1, 0);
                else begin
                    l = lq.pop_front();
                    chk("launch_params", eng_if.eng_params, l.prm);
                    chk("launch_cycle", cyc, l.cy);
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.cy);
                    chk("done_busy", busy, 0);
                    chk("ch_valid", ch_valid, d.valid);
                    chk("timing", timing, d.tim);
                    chk("timeout_err", timeout_err, d.terr);
                    chk("err_ch", err_ch, d.ech);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        go(1, 5'b11111, t0); plan_run(1, 5'b11111, -1, t0); drain(400);
        go(2, 5'b10010, t0); plan_run(2, 5'b10010, -1, t0); drain(400);
        go(3, 5'b00000, t0); plan_run(3, 5'b00000, -1, t0); drain(20);

        skip_ch = 2;
        go(4, 5'b00111, t0); plan_run(4, 5'b00111, 2, t0); drain(400);
        skip_ch = -1;

        // Abort during WAIT on channel 3; completed channels 0..2 survive.
        go(5, 5'b11111, t0);
        plan_run(5, 5'b00111, -1, t0);
        dq.delete();
        begin
            launch_t l;
            logic [PV-1:0] p;
            p = make_params(5);
            l.prm = p[3*N_PARAM*PW +: N_PARAM*PW];
            l.cy  = t0 + 2 + 3*(GAP + 13);
            lq.push_back(l);
        end
        wait_cyc(t0 + 105);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ch_valid", ch_valid, 5'b00111);
        repeat (30) @(posedge clk);
        #1;
        chk("abort_late_valid", ch_valid, m_valid);
        chk("abort_late_timing", timing, m_tim);
        chk("abort_late_busy", busy, 0);
        chk("abort_lq_empty", lq.size(), 0);

        // Abort and start together in IDLE: the start is dropped.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; ch_mask = 5'b11111;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_start_idle", busy, 0);

        // Params and start changes while busy must not disturb the run.
        go(6, 5'b11111, t0); plan_run(6, 5'b11111, -1, t0);
        wait_cyc(t0 + 50);
        params = make_params(7); ch_mask = 5'b00001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain(400);
        repeat (60) @(posedge clk);
        #1;
        chk("no_second_run", busy, 0);
        chk("no_second_lq", lq.size(), 0);

        // Asynchronous reset in the middle of WAIT.
        go(8, 5'b11111, t0);
        begin
            launch_t l;
            logic [PV-1:0] p;
            p = make_params(8);
            l.prm = p[0 +: N_PARAM*PW];
            l.cy  = t0 + 2;
            lq.push_back(l);
        end
        wait_cyc(t0 + 6);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        chk("async_reset_lq", lq.size(), 0);
        m_tim = '0; m_valid = '0; m_terr = 1'b0; m_ech = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);

        go(9, 5'b00001, t0); plan_run(9, 5'b00001, -1, t0); drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/calc_times_seq.md
Name: calc_times_seq

Overview:
- Parametrised scheduler that time-multiplexes one shared motion-timing engine (calc_time-style: N_PARAM params in, N_TIME timings out) across N_CH axis channels.
- Successor to the fixed 5-axis sequencer. Adds:
  - a per-channel enable mask (idle axes are skipped),
  - an input snapshot taken at start,
  - a done pulse and per-channel valid flags,
  - a per-run engine timeout with error reporting,
  - abort.
- Sits between the G-code move decoder and the per-axis step generators.

Parameters:
- N_CH, 5, number of axis channels (x, y, z, e0, e1 by default).
- N_PARAM, 5, parameter words per channel.
- PW, 32, parameter word width.
- N_TIME, 4, timing words per channel.
- TW, 64, timing word width.
- GAP, 20, idle cycles between successive engine runs; 0 means no gap.
- TIMEOUT, 65535, maximum cycles to wait for eng_done per run; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- start  in  1  start request, sampled only in IDLE.
- abort  in  1  cancel the current sequence.
- ch_mask  in  N_CH  bit i=1 means channel i is computed.
- params  in  N_CH*N_PARAM*PW  flattened parameters; channel i occupies slice [i*N_PARAM*PW +: N_PARAM*PW].
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at normal completion.
- timing  out  N_CH*N_TIME*TW  flattened per-channel timing results.
- ch_valid  out  N_CH  bit i=1 means timing for channel i is fresh from this sequence.
- timeout_err  out  1  sticky until the next accepted start; at least one channel timed out.
- err_ch  out  $clog2(N_CH)  channel of the most recent timeout.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_params  out  N_PARAM*PW  parameters presented to the engine.
- eng_timing  in  N_TIME*TW  engine result.
- eng_done  in  1  one-cycle engine completion pulse.

Behaviour:

Reset:
- On reset, all outputs go to 0.
- State goes to IDLE.
- Snapshot registers and counters are cleared.

FSM states:
- IDLE:
  - start=1 and abort=0 → snapshot params and ch_mask into pending; clear ch_valid and timeout_err; busy=1; go to SELECT.
- SELECT:
  - Pick the lowest-index pending channel c.
  - Load eng_params from snap[c].
  - Go to LAUNCH.
  - If no channel is pending → go to DONE.
- LAUNCH:
  - eng_start=1 for exactly this cycle.
  - Reset the timeout counter.
  - Go to WAIT.
- WAIT:
  - eng_done=1 → timing[c] ← eng_timing, ch_valid[c] ← 1, pending[c] ← 0; go to GAP (or SELECT if GAP=0).
  - Counter reaches TIMEOUT (when TIMEOUT≠0) → timeout_err ← 1, err_ch ← c, pending[c] ← 0; timing[c] keeps its prior value; go to GAP or SELECT.
  - eng_done and timeout in the same cycle → done wins.
- GAP:
  - Count GAP cycles, then go to SELECT.
- DONE:
  - done=1 for one cycle, busy=0, go to IDLE.

Timing:
- start sampled at cycle T → eng_start high at T+2.
- eng_done at cycle D → timing and ch_valid visible at D+1; next eng_start at D+GAP+3.
- Mask all-zero → done at T+3, with no engine launch.

Input and handshake rules:
- params and ch_mask changes while busy have no effect.
- start while busy is ignored.
- eng_done outside WAIT is ignored.

Abort:
- In any non-IDLE state, abort=1 → IDLE on the next edge.
- busy=0, no done pulse, eng_start=0.
- ch_valid and timing of already-completed channels are retained; pending is cleared.
- abort and start in the same cycle in IDLE → abort wins; the start is dropped.

Reset mid-operation:
- Asynchronous return to the reset values; any in-flight engine result is discarded.

Decomposition:
- Package calc_times_pkg holds:
  - the state enum typedef,
  - the default width constants (PW, TW, N_PARAM, N_TIME),
  - the slice-index helper function.
- One natural sub-module: calc_times_prienc, a parametrised lowest-set-bit priority encoder producing the index and a none-pending flag.

Test Plan:
- mask=5'b11111, engine stub with 10-cycle latency returning {ch,k} words, GAP=20 → five eng_start pulses spaced 10+20+3 cycles; timing[i] matches stub; ch_valid=5'b11111; one done pulse; timeout_err=0.
- mask=5'b10010 → exactly two launches, ch1 then ch4; ch_valid=5'b10010; timing of ch0/2/3 unchanged.
- mask=0 → no eng_start; done pulse at T+3.
- TIMEOUT=100, stub never answers ch2, mask=5'b00111 → timeout_err=1, err_ch=2, ch_valid=5'b00011; sequence completes with done.
- abort asserted during WAIT on ch3 of a full-mask run → busy=0 next cycle, no done, ch_valid=5'b00111; a late eng_done is ignored.
- params changed mid-run plus start re-asserted while busy → results match the snapshot; no second sequence starts; async reset mid-WAIT → all outputs 0 immediately.
